cpu_axi_bridge: RTL
===================

Name: cpu_axi_bridge

Overview:
- Parametrised bridge between NUM_MST SRAM-like CPU request ports (default 2: port 0 = instruction fetch, port 1 = data) and one AXI3 master interface.
- Sits between the pipeline core and the system interconnect inside mycpu_top.
- Single-beat transfers only.
- Arbitrates requests and tags reads with the master index as ARID.
- Allows one outstanding read per master and one outstanding write in total.
- Blocks read-after-write hazards.

Parameters:
NUM_MST, 2, number of request ports (1..4); index also used as AXI ID
ID_W, 4, AXI ID width; must satisfy 2**ID_W >= NUM_MST
ADDR_W, 32, address width

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
req_valid  in  NUM_MST  per-port request valid
req_wr  in  NUM_MST  1 = write, 0 = read
req_size  in  2*NUM_MST  0 = byte, 1 = half, 2 = word (drives AxSIZE)
req_addr  in  ADDR_W*NUM_MST  byte address
req_wdata  in  32*NUM_MST  write data
req_wstrb  in  4*NUM_MST  byte strobes
req_ready  out  NUM_MST  request accepted this cycle
resp_valid  out  NUM_MST  one-cycle response pulse (read data or write ack)
resp_rdata  out  32  read data, shared; qualified by resp_valid
resp_err  out  1  RRESP/BRESP[1] of the current response
cpu_arid/araddr/arsize/arvalid  out  ID_W/ADDR_W/3/1  AXI read address channel
cpu_arlen/arburst/arlock/arcache/arprot  out  8/2/2/4/3  constants 0/1/0/0/0
cpu_arready  in  1
cpu_rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1  read data channel
cpu_rready  out  1  constant 1
cpu_awid/awaddr/awsize/awvalid  out  ID_W/ADDR_W/3/1  write address channel
cpu_awlen/awburst/awlock/awcache/awprot  out  8/2/2/4/3  constants 0/1/0/0/0
cpu_awready  in  1
cpu_wid/wdata/wstrb/wlast/wvalid  out  ID_W/32/4/1/1  write data channel; wlast = 1
cpu_wready  in  1
cpu_bid/bresp/bvalid  in  ID_W/2/1  write response channel
cpu_bready  out  1  constant 1

Behaviour:
- Reset (async, resetn = 0): all valid outputs 0; req_ready 0; resp_valid 0; resp_rdata 0; resp_err 0; IDs and addresses 0; rd_busy[] cleared; write FSM in W_IDLE; RR pointer 0. Release takes effect on the next edge.
- Eligibility: port i is eligible if req_valid[i] and:
  - read: rd_busy[i] = 0, AR FSM idle, and no RAW hazard;
  - write: write FSM in W_IDLE.
- Grant: one port per cycle. req_ready[grant] = 1 combinationally in the grant cycle only. Acceptance = req_valid & req_ready.
- Read path (AR FSM AR_IDLE -> AR_REQ):
  - On accept: latch addr/size; ARID = i; set rd_busy[i]; cpu_arvalid = 1 the next cycle.
  - arvalid and payload are held stable until cpu_arready, then return to AR_IDLE.
  - rvalid with rid = i: resp_valid[i] = 1 one cycle later with rdata/rresp; clear rd_busy[i].
  - rid not busy: response dropped; rd_busy unchanged.
- Write path (W_IDLE -> W_SEND -> W_RESP -> W_IDLE):
  - W_SEND: cpu_awvalid and cpu_wvalid rise in the same cycle. Each drops independently on its own ready.
  - Leave W_SEND once both handshakes have completed, including same-cycle completion.
  - W_RESP: on bvalid, resp_valid[owner] = 1 one cycle later, resp_err = bresp[1]; return to W_IDLE.
- RAW hazard: a read whose address[ADDR_W-1:2] equals the pending write address (W_SEND or W_RESP) is not granted until the FSM returns to W_IDLE.
- Response collision: read and write responses in the same cycle → read response first; write response registered and issued the following cycle. rvalid must not be lost.
- Minimum latency: accept to arvalid = 1 cycle; rvalid to resp_valid = 1 cycle.
- Reset mid-transaction: all state discarded; no response emitted afterwards.

Optional Feature:
- CPU_AXI_BRIDGE_RR_EN defined: round-robin arbitration. Pointer advances to grant+1 mod NUM_MST after each accept; search starts at the pointer.
- Undefined: fixed priority, lowest index wins; no pointer register.

Test Plan:
- Port 0 reads 0xBFC00000; arready after 2 cycles; rvalid rid = 0 rdata 0x3C1D0001 → arid = 0, arvalid held 2 cycles, resp_valid[0] one cycle after rvalid, resp_rdata = 0x3C1D0001.
- Port 1 writes 0x80001004 data 0xDEADBEEF wstrb 0xF; wready 3 cycles before awready → both valids start together, each drops on its own ready; bvalid → resp_valid[1], resp_err = 0.
- Port 1 write to 0x80000010 pending, then port 0 read of 0x80000012 → no req_ready[0] until bvalid processed; arvalid follows.
- Both ports request reads continuously with RR_EN defined → grants alternate 0, 1, 0, 1; with RR_EN undefined, port 0 wins every cycle it is eligible.
- rvalid (rid = 1) and bvalid coincide → resp_valid[1] read data in cycle N+1, write ack in N+2; both present.
- resetn deasserted asynchronously while in W_SEND → awvalid/wvalid drop immediately, no resp_valid after release.

Source files
------------

// File: rtl/cpu_axi_bridge.sv
// rtl/cpu_axi_bridge.sv - NUM_MST SRAM-like request ports to one AXI3 master, single-beat transfers
// Define CPU_AXI_BRIDGE_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module cpu_axi_bridge #(
  parameter int NUM_MST = 2,
  parameter int ID_W    = 4,
  parameter int ADDR_W  = 32
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_MST-1:0]        req_valid,
  input  logic [NUM_MST-1:0]        req_wr,
  input  logic [2*NUM_MST-1:0]      req_size,
  input  logic [ADDR_W*NUM_MST-1:0] req_addr,
  input  logic [32*NUM_MST-1:0]     req_wdata,
  input  logic [4*NUM_MST-1:0]      req_wstrb,
  output logic [NUM_MST-1:0]        req_ready,
  output logic [NUM_MST-1:0]        resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_err,
  output logic [ID_W-1:0]           cpu_arid,
  output logic [ADDR_W-1:0]         cpu_araddr,
  output logic [2:0]                cpu_arsize,
  output logic                      cpu_arvalid,
  output logic [7:0]                cpu_arlen,
  output logic [1:0]                cpu_arburst,
  output logic [1:0]                cpu_arlock,
  output logic [3:0]                cpu_arcache,
  output logic [2:0]                cpu_arprot,
  input  logic                      cpu_arready,
  input  logic [ID_W-1:0]           cpu_rid,
  input  logic [31:0]               cpu_rdata,
  input  logic [1:0]                cpu_rresp,
  input  logic                      cpu_rlast,
  input  logic                      cpu_rvalid,
  output logic                      cpu_rready,
  output logic [ID_W-1:0]           cpu_awid,
  output logic [ADDR_W-1:0]         cpu_awaddr,
  output logic [2:0]                cpu_awsize,
  output logic                      cpu_awvalid,
  output logic [7:0]                cpu_awlen,
  output logic [1:0]                cpu_awburst,
  output logic [1:0]                cpu_awlock,
  output logic [3:0]                cpu_awcache,
  output logic [2:0]                cpu_awprot,
  input  logic                      cpu_awready,
  output logic [ID_W-1:0]           cpu_wid,
  output logic [31:0]               cpu_wdata,
  output logic [3:0]                cpu_wstrb,
  output logic                      cpu_wlast,
  output logic                      cpu_wvalid,
  input  logic                      cpu_wready,
  input  logic [ID_W-1:0]           cpu_bid,
  input  logic [1:0]                cpu_bresp,
  input  logic                      cpu_bvalid,
  output logic                      cpu_bready
);

  localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  typedef enum logic {AR_IDLE, AR_REQ} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

  ar_state_t ar_state, ar_next;
  w_state_t  w_state, w_next;

  logic [NUM_MST-1:0] rd_busy;
  logic [ID_W-1:0]    ar_id_q, w_id_q;
  logic [ADDR_W-1:0]  ar_addr_q, aw_addr_q;
  logic [2:0]         ar_size_q, aw_size_q;
  logic [31:0]        w_data_q;
  logic [3:0]         w_strb_q;
  logic               aw_pend, w_pend;
  logic               b_held, b_err_q;
  logic [NUM_MST-1:0] resp_valid_q;
  logic [31:0]        resp_rdata_q;
  logic               resp_err_q;

  logic [NUM_MST-1:0] elig, gnt_vec, rd_hit, w_onehot;
  logic               gnt_found;
  logic [IDX_W-1:0]   gnt_idx, cand;
  logic [IDX_W:0]     cand_sum;
  logic               accept, acc_rd, acc_wr, sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [1:0]         sel_size;
  logic [31:0]        sel_wdata;
  logic [3:0]         sel_wstrb;
  logic               rd_any, b_now, wr_resp_go;

`ifdef CPU_AXI_BRIDGE_RR_EN
  logic [IDX_W-1:0]   rr_ptr;
`endif

  // A read is held off while a write to the same word is still in flight.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (req_valid[i]) begin
        if (req_wr[i])
          elig[i] = (w_state == W_IDLE);
        else
          elig[i] = !rd_busy[i] && (ar_state == AR_IDLE) &&
                    !((w_state != W_IDLE) &&
                      (req_addr[i*ADDR_W+2 +: ADDR_W-2] == aw_addr_q[ADDR_W-1:2]));
      end
    end
  end

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int k = 0; k < NUM_MST; k++) begin
`ifdef CPU_AXI_BRIDGE_RR_EN
      cand_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
`else
      cand_sum = (IDX_W+1)'(k);
`endif
      if (cand_sum >= (IDX_W+1)'(NUM_MST))
        cand_sum = cand_sum - (IDX_W+1)'(NUM_MST);
      cand = cand_sum[IDX_W-1:0];
      if (!gnt_found && elig[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    gnt_vec   = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_size  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      if (gnt_found && (gnt_idx == IDX_W'(i))) begin
        gnt_vec[i] = 1'b1;
        sel_wr     = req_wr[i];
        sel_addr   = req_addr[i*ADDR_W +: ADDR_W];
        sel_size   = req_size[i*2 +: 2];
        sel_wdata  = req_wdata[i*32 +: 32];
        sel_wstrb  = req_wstrb[i*4 +: 4];
      end
    end
  end

  assign req_ready = resetn ? gnt_vec : '0;
  assign accept    = resetn && gnt_found;
  assign acc_rd    = accept && !sel_wr;
  assign acc_wr    = accept && sel_wr;

  always_comb begin
    rd_hit   = '0;
    w_onehot = '0;
    for (int i = 0; i < NUM_MST; i++) begin
      rd_hit[i]   = cpu_rvalid && (cpu_rid == ID_W'(i)) && rd_busy[i];
      w_onehot[i] = (w_id_q == ID_W'(i));
    end
  end

  // Read responses win a collision; the write ack waits in b_held for one slot.
  assign rd_any     = |rd_hit;
  assign b_now      = cpu_bvalid && (w_state == W_RESP) && !b_held;
  assign wr_resp_go = !rd_any && (b_held || b_now);

  always_comb begin
    ar_next = ar_state;
    case (ar_state)
      AR_IDLE: if (acc_rd) ar_next = AR_REQ;
      AR_REQ:  if (cpu_arready) ar_next = AR_IDLE;
      default: ar_next = AR_IDLE;
    endcase
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE: if (acc_wr) w_next = W_SEND;
      W_SEND: if ((!aw_pend || cpu_awready) && (!w_pend || cpu_wready)) w_next = W_RESP;
      W_RESP: if (wr_resp_go) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_state <= AR_IDLE;
      w_state  <= W_IDLE;
    end else begin
      ar_state <= ar_next;
      w_state  <= w_next;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_busy      <= '0;
      ar_id_q      <= '0;
      ar_addr_q    <= '0;
      ar_size_q    <= '0;
      w_id_q       <= '0;
      aw_addr_q    <= '0;
      aw_size_q    <= '0;
      w_data_q     <= '0;
      w_strb_q     <= '0;
      aw_pend      <= 1'b0;
      w_pend       <= 1'b0;
      b_held       <= 1'b0;
      b_err_q      <= 1'b0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      if (acc_rd) begin
        ar_id_q   <= ID_W'(gnt_idx);
        ar_addr_q <= sel_addr;
        ar_size_q <= {1'b0, sel_size};
      end
      rd_busy <= (rd_busy & ~rd_hit) | (acc_rd ? gnt_vec : '0);

      if (acc_wr) begin
        w_id_q    <= ID_W'(gnt_idx);
        aw_addr_q <= sel_addr;
        aw_size_q <= {1'b0, sel_size};
        w_data_q  <= sel_wdata;
        w_strb_q  <= sel_wstrb;
        aw_pend   <= 1'b1;
        w_pend    <= 1'b1;
      end else if (w_state == W_SEND) begin
        if (cpu_awready) aw_pend <= 1'b0;
        if (cpu_wready)  w_pend  <= 1'b0;
      end

      resp_valid_q <= '0;
      if (rd_any) begin
        resp_valid_q <= rd_hit;
        resp_rdata_q <= cpu_rdata;
        resp_err_q   <= cpu_rresp[1];
        if (b_now) begin
          b_held  <= 1'b1;
          b_err_q <= cpu_bresp[1];
        end
      end else if (b_held) begin
        resp_valid_q <= w_onehot;
        resp_err_q   <= b_err_q;
        b_held       <= 1'b0;
      end else if (b_now) begin
        resp_valid_q <= w_onehot;
        resp_err_q   <= cpu_bresp[1];
      end
    end
  end

`ifdef CPU_AXI_BRIDGE_RR_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (gnt_idx == IDX_W'(NUM_MST-1)) ? '0 : gnt_idx + 1'b1;
  end
`endif

  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_err    = resp_err_q;

  assign cpu_arid    = ar_id_q;
  assign cpu_araddr  = ar_addr_q;
  assign cpu_arsize  = ar_size_q;
  assign cpu_arvalid = (ar_state == AR_REQ);
  assign cpu_arlen   = 8'd0;
  assign cpu_arburst = 2'b01;
  assign cpu_arlock  = 2'b00;
  assign cpu_arcache = 4'd0;
  assign cpu_arprot  = 3'd0;
  assign cpu_rready  = 1'b1;

  assign cpu_awid    = w_id_q;
  assign cpu_awaddr  = aw_addr_q;
  assign cpu_awsize  = aw_size_q;
  assign cpu_awvalid = (w_state == W_SEND) && aw_pend;
  assign cpu_awlen   = 8'd0;
  assign cpu_awburst = 2'b01;
  assign cpu_awlock  = 2'b00;
  assign cpu_awcache = 4'd0;
  assign cpu_awprot  = 3'd0;

  assign cpu_wid     = w_id_q;
  assign cpu_wdata   = w_data_q;
  assign cpu_wstrb   = w_strb_q;
  assign cpu_wlast   = 1'b1;
  assign cpu_wvalid  = (w_state == W_SEND) && w_pend;
  assign cpu_bready  = 1'b1;

  logic unused_inputs;
  assign unused_inputs = ^{cpu_rlast, cpu_bid, cpu_rresp[0], cpu_bresp[0]};

endmodule
